// File: rtl/piece_move_validator.sv
// Owns the active piece's position/rotation and checks each spawn or move request
// against the 6x6 board window, committing or rejecting it two cycles later.
module piece_move_validator #(
  parameter  int BOARD_WIDTH  = 10,
  parameter  int BOARD_HEIGHT = 20,
  localparam int XW           = $clog2(BOARD_WIDTH),
  localparam int YW           = $clog2(BOARD_HEIGHT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            spawn_valid,
  input  logic [XW-1:0]   spawn_x,
  input  logic            move_valid,
  input  logic [1:0]      move_op,
  output logic            move_ready,
  input  logic [15:0]     cur_mask,
  input  logic [15:0]     next_mask,
  input  logic [5:0][5:0] window,
  output logic [XW-1:0]   piece_x,
  output logic [YW-1:0]   piece_y,
  output logic [1:0]      piece_rot,
  output logic            piece_active,
  output logic            done,
  output logic            accepted,
  output logic            locked,
  output logic            game_over
);

  typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_EVAL} state_e;
  typedef enum logic [1:0] {OP_LEFT, OP_RIGHT, OP_DOWN, OP_ROT_CW} move_op_e;

  state_e          state_q, state_d;
  logic            spawn_q, spawn_d;
  move_op_e        op_q, op_d;
  logic [5:0][5:0] window_q, window_d;
  logic [15:0]     cur_q, cur_d;
  logic [15:0]     next_q, next_d;
  logic [XW-1:0]   piece_x_q, piece_x_d;
  logic [YW-1:0]   piece_y_q, piece_y_d;
  logic [1:0]      piece_rot_q, piece_rot_d;
  logic            active_q, active_d;
  logic            game_over_q, game_over_d;

  // Board occupancy under each mask cell for every candidate offset, indexed like the mask.
  logic [15:0] occ_same, occ_left, occ_right, occ_down;
  logic [15:0] mask_sel, occ_sel;
  logic        guard, hit;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign occ_same[4*r+c]  = window_q[c+1][r+1];
      assign occ_left[4*r+c]  = window_q[c][r+1];
      assign occ_right[4*r+c] = window_q[c+2][r+1];
      assign occ_down[4*r+c]  = window_q[c+1][r+2];
    end
  end

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mask_sel = cur_q;
    occ_sel  = occ_same;
    guard    = 1'b0;
    if (!spawn_q) begin
      unique case (op_q)
        OP_LEFT: begin
          occ_sel = occ_left;
          guard   = (piece_x_q == '0);
        end
        OP_RIGHT: begin
          occ_sel = occ_right;
          guard   = (piece_x_q == XW'(BOARD_WIDTH - 1));
        end
        OP_DOWN: begin
          occ_sel = occ_down;
          guard   = (piece_y_q == YW'(BOARD_HEIGHT - 1));
        end
        OP_ROT_CW: mask_sel = next_q;
      endcase
    end
    hit = guard | (|(mask_sel & occ_sel));
  end

  always_comb begin
    state_d     = state_q;
    spawn_d     = spawn_q;
    op_d        = op_q;
    window_d    = window_q;
    cur_d       = cur_q;
    next_d      = next_q;
    piece_x_d   = piece_x_q;
    piece_y_d   = piece_y_q;
    piece_rot_d = piece_rot_q;
    active_d    = active_q;
    game_over_d = game_over_q;
    done        = 1'b0;
    accepted    = 1'b0;
    locked      = 1'b0;
    move_ready  = !reset && (state_q == ST_IDLE) && !spawn_valid && !game_over_q;

    unique case (state_q)
      ST_IDLE: begin
        if (spawn_valid && !game_over_q) begin
          spawn_d     = 1'b1;
          piece_x_d   = spawn_x;
          piece_y_d   = '0;
          piece_rot_d = '0;
          active_d    = 1'b1;
          state_d     = ST_SAMPLE;
        end else if (move_valid && move_ready && active_q) begin
          spawn_d = 1'b0;
          op_d    = move_op_e'(move_op);
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        window_d = window;
        cur_d    = cur_mask;
        next_d   = next_mask;
        state_d  = ST_EVAL;
      end
      ST_EVAL: begin
        done    = 1'b1;
        state_d = ST_IDLE;
        if (spawn_q) begin
          if (hit) begin
            game_over_d = 1'b1;
            active_d    = 1'b0;
          end else begin
            accepted = 1'b1;
          end
        end else if (hit) begin
          if (op_q == OP_DOWN) begin
            locked   = 1'b1;
            active_d = 1'b0;
          end
        end else begin
          accepted = 1'b1;
          unique case (op_q)
            OP_LEFT:   piece_x_d   = piece_x_q - 1'b1;
            OP_RIGHT:  piece_x_d   = piece_x_q + 1'b1;
            OP_DOWN:   piece_y_d   = piece_y_q + 1'b1;
            OP_ROT_CW: piece_rot_d = piece_rot_q + 2'd1;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset landing in EVAL aborts the request without a visible pulse.
    if (reset) begin
      done     = 1'b0;
      accepted = 1'b0;
      locked   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      spawn_q     <= 1'b0;
      op_q        <= OP_LEFT;
      piece_x_q   <= '0;
      piece_y_q   <= '0;
      piece_rot_q <= '0;
      active_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      spawn_q     <= spawn_d;
      op_q        <= op_d;
      piece_x_q   <= piece_x_d;
      piece_y_q   <= piece_y_d;
      piece_rot_q <= piece_rot_d;
      active_q    <= active_d;
      game_over_q <= game_over_d;
    end
  end

  // NOTE: the snapshot registers carry no reset; SAMPLE always writes them before EVAL reads them.
  always_ff @(posedge clk) begin
    window_q <= window_d;
    cur_q    <= cur_d;
    next_q   <= next_d;
  end

  assign piece_x      = piece_x_q;
  assign piece_y      = piece_y_q;
  assign piece_rot    = piece_rot_q;
  assign piece_active = active_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_piece_move_validator.sv
// Self-checking bench for piece_move_validator: a board model stands in for the
// mask generator, a vector table drives requests, hand sequences cover corner cases.
module tb_piece_move_validator;

  localparam int W = 10;
  localparam int H = 20;
  localparam logic [1:0] OP_L = 2'd0, OP_R = 2'd1, OP_D = 2'd2, OP_ROT = 2'd3;

  typedef struct {
    logic       sp;
    logic [3:0] sx;
    logic [1:0] op;
    int         shape;   // 0 = O, 1 = I, 2 = empty
    logic       clr;
    int         px;      // board cell poked before the request; px < 0 means none
    int         py;
    logic       pv;
    logic       e_acc;
    logic       e_lk;
    logic [3:0] e_x;
    logic [4:0] e_y;
    logic [1:0] e_rot;
    logic       e_act;
    logic       e_go;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            spawn_valid;
  logic [3:0]      spawn_x;
  logic            move_valid;
  logic [1:0]      move_op;
  logic            move_ready;
  logic [15:0]     cur_mask;
  logic [15:0]     next_mask;
  logic [5:0][5:0] window;
  logic [3:0]      piece_x;
  logic [4:0]      piece_y;
  logic [1:0]      piece_rot;
  logic            piece_active;
  logic            done;
  logic            accepted;
  logic            locked;
  logic            game_over;

  logic [W*H-1:0]  board;
  logic [15:0]     rom [4];
  logic [1:0]      rot_n;
  int              checks = 0;
  int              errors = 0;
  vec_t            vecs [21];

  always #5 clk = ~clk;

  piece_move_validator #(.BOARD_WIDTH(W), .BOARD_HEIGHT(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .spawn_valid  (spawn_valid),
    .spawn_x      (spawn_x),
    .move_valid   (move_valid),
    .move_op      (move_op),
    .move_ready   (move_ready),
    .cur_mask     (cur_mask),
    .next_mask    (next_mask),
    .window       (window),
    .piece_x      (piece_x),
    .piece_y      (piece_y),
    .piece_rot    (piece_rot),
    .piece_active (piece_active),
    .done         (done),
    .accepted     (accepted),
    .locked       (locked),
    .game_over    (game_over)
  );

  // Shape ROM and mask generator stand-ins.
  assign rot_n     = piece_rot + 2'd1;
  assign cur_mask  = rom[piece_rot];
  assign next_mask = rom[rot_n];

  always_comb begin
    window = '1;
    for (int lx = 0; lx < 6; lx++)
      for (int ly = 0; ly < 6; ly++)
        if (int'(piece_x) + lx - 1 >= 0 && int'(piece_x) + lx - 1 < W &&
            int'(piece_y) + ly - 1 >= 0 && int'(piece_y) + ly - 1 < H)
          window[lx][ly] = board[(int'(piece_y) + ly - 1) * W + int'(piece_x) + lx - 1];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_shape(input int s);
    case (s)
      0:       begin rom[0] = 16'h0033; rom[1] = 16'h0033; rom[2] = 16'h0033; rom[3] = 16'h0033; end
      1:       begin rom[0] = 16'h00F0; rom[1] = 16'h2222; rom[2] = 16'h0F00; rom[3] = 16'h4444; end
      default: begin rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h0000; rom[3] = 16'h0000; end
    endcase
  endtask

  task automatic set_cell(input int x, input int y, input logic v);
    board[y * W + x] = v;
  endtask

  // Drive one request for a single cycle and wait (bounded) for done.
  task automatic issue(input logic sp, input logic [3:0] sx, input logic [1:0] op,
                       output logic got, output int lat, output logic acc, output logic lk);
    @(negedge clk);
    spawn_valid = sp;
    spawn_x     = sx;
    move_valid  = !sp;
    move_op     = op;
    @(negedge clk);
    spawn_valid = 1'b0;
    move_valid  = 1'b0;
    lat = 1;
    while (!done && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    got = done;
    acc = accepted;
    lk  = locked;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " piece_x"}, piece_x, 0);
    check({tag, " piece_y"}, piece_y, 0);
    check({tag, " piece_rot"}, piece_rot, 0);
    check({tag, " piece_active"}, piece_active, 0);
    check({tag, " done"}, done, 0);
    check({tag, " accepted"}, accepted, 0);
    check({tag, " locked"}, locked, 0);
    check({tag, " game_over"}, game_over, 0);
    check({tag, " move_ready"}, move_ready, 0);
  endtask

  task automatic run_vec(input int idx);
    logic got, acc, lk;
    int   lat;
    if (vecs[idx].clr) board = '0;
    set_shape(vecs[idx].shape);
    if (vecs[idx].px >= 0) set_cell(vecs[idx].px, vecs[idx].py, vecs[idx].pv);
    issue(vecs[idx].sp, vecs[idx].sx, vecs[idx].op, got, lat, acc, lk);
    check($sformatf("v%0d latency", idx), lat, 2);
    check($sformatf("v%0d accepted", idx), acc, vecs[idx].e_acc);
    check($sformatf("v%0d locked", idx), lk, vecs[idx].e_lk);
    @(negedge clk);
    check($sformatf("v%0d done_pulse", idx), done, 0);
    check($sformatf("v%0d piece_x", idx), piece_x, vecs[idx].e_x);
    check($sformatf("v%0d piece_y", idx), piece_y, vecs[idx].e_y);
    check($sformatf("v%0d piece_rot", idx), piece_rot, vecs[idx].e_rot);
    check($sformatf("v%0d piece_active", idx), piece_active, vecs[idx].e_act);
    check($sformatf("v%0d game_over", idx), game_over, vecs[idx].e_go);
  endtask

  task automatic down_run(input int n, input string tag);
    logic got, acc, lk;
    int   lat;
    for (int k = 0; k < n; k++) begin
      issue(1'b0, 4'd0, OP_D, got, lat, acc, lk);
      check($sformatf("%s down%0d accepted", tag, k), acc, 1);
    end
    @(negedge clk);
  endtask

  initial begin
    logic got, acc, lk;
    int   lat, extra;

    //            sp sx  op      shp clr px  py pv  acc lk x  y  rot act go
    vecs[0]  = '{1, 3, OP_L,   0, 1, -1, 0, 0,  1,  0, 3, 0, 0,  1,  0};
    vecs[1]  = '{0, 0, OP_L,   0, 0, -1, 0, 0,  1,  0, 2, 0, 0,  1,  0};
    vecs[2]  = '{0, 0, OP_L,   0, 0, -1, 0, 0,  1,  0, 1, 0, 0,  1,  0};
    vecs[3]  = '{0, 0, OP_L,   0, 0, -1, 0, 0,  1,  0, 0, 0, 0,  1,  0};
    vecs[4]  = '{0, 0, OP_L,   0, 0, -1, 0, 0,  0,  0, 0, 0, 0,  1,  0};
    vecs[5]  = '{0, 0, OP_R,   0, 0, -1, 0, 0,  1,  0, 1, 0, 0,  1,  0};
    vecs[6]  = '{0, 0, OP_D,   0, 0, -1, 0, 0,  1,  0, 1, 1, 0,  1,  0};
    vecs[7]  = '{0, 0, OP_ROT, 0, 0, -1, 0, 0,  1,  0, 1, 1, 1,  1,  0};
    vecs[8]  = '{0, 0, OP_R,   0, 0,  3, 2, 1,  0,  0, 1, 1, 1,  1,  0};
    vecs[9]  = '{0, 0, OP_D,   0, 0, -1, 0, 0,  1,  0, 1, 2, 1,  1,  0};
    vecs[10] = '{1, 3, OP_L,   1, 1, -1, 0, 0,  1,  0, 3, 0, 0,  1,  0};
    vecs[11] = '{0, 0, OP_ROT, 1, 0,  4, 2, 1,  0,  0, 3, 0, 0,  1,  0};
    vecs[12] = '{0, 0, OP_ROT, 1, 0,  4, 2, 0,  1,  0, 3, 0, 1,  1,  0};
    vecs[13] = '{0, 0, OP_ROT, 1, 0, -1, 0, 0,  1,  0, 3, 0, 2,  1,  0};
    vecs[14] = '{0, 0, OP_ROT, 1, 0, -1, 0, 0,  1,  0, 3, 0, 3,  1,  0};
    vecs[15] = '{0, 0, OP_ROT, 1, 0, -1, 0, 0,  1,  0, 3, 0, 0,  1,  0};
    vecs[16] = '{1, 9, OP_L,   2, 1, -1, 0, 0,  1,  0, 9, 0, 0,  1,  0};
    vecs[17] = '{0, 0, OP_R,   2, 0, -1, 0, 0,  0,  0, 9, 0, 0,  1,  0};
    vecs[18] = '{0, 0, OP_L,   2, 0, -1, 0, 0,  1,  0, 8, 0, 0,  1,  0};
    vecs[19] = '{0, 0, OP_R,   2, 0, -1, 0, 0,  1,  0, 9, 0, 0,  1,  0};
    vecs[20] = '{1, 5, OP_L,   0, 1,  5, 0, 1,  0,  0, 5, 0, 0,  0,  1};

    reset       = 1'b1;
    spawn_valid = 1'b0;
    spawn_x     = '0;
    move_valid  = 1'b0;
    move_op     = '0;
    board       = '0;
    set_shape(0);

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("post-reset move_ready", move_ready, 1);

    // O-piece moves, range guards at the left wall and a board collision.
    for (int i = 0; i <= 9; i++) run_vec(i);

    // Floor of filled cells on row 19: drop from y=2 to y=17, then the blocked DOWN locks.
    for (int x = 0; x < W; x++) set_cell(x, H - 1, 1'b1);
    down_run(15, "floor");
    check("floor piece_y", piece_y, 17);
    issue(1'b0, 4'd0, OP_D, got, lat, acc, lk);
    check("lock done", got, 1);
    check("lock accepted", acc, 0);
    check("lock locked", lk, 1);
    @(negedge clk);
    check("lock piece_active", piece_active, 0);
    check("lock piece_y", piece_y, 17);
    issue(1'b0, 4'd0, OP_L, got, lat, acc, lk);
    check("inactive move done", got, 0);
    check("inactive move piece_x", piece_x, 1);

    // I-piece rotation blocked, then four rotations wrapping back to 0.
    for (int i = 10; i <= 15; i++) run_vec(i);

    // Empty mask isolates the right-wall and bottom-row guards from the window.
    for (int i = 16; i <= 19; i++) run_vec(i);
    down_run(19, "guard");
    check("guard piece_y", piece_y, 19);
    issue(1'b0, 4'd0, OP_D, got, lat, acc, lk);
    check("bottom guard accepted", acc, 0);
    check("bottom guard locked", lk, 1);
    @(negedge clk);
    check("bottom guard piece_y", piece_y, 19);
    check("bottom guard piece_active", piece_active, 0);

    // Blocked spawn: game over is sticky and further spawns are ignored.
    run_vec(20);
    check("game_over move_ready", move_ready, 0);
    board = '0;
    issue(1'b1, 4'd2, OP_L, got, lat, acc, lk);
    check("spawn after game_over done", got, 0);
    check("spawn after game_over sticky", game_over, 1);
    check("spawn after game_over piece_x", piece_x, 5);
    reset = 1'b1;
    @(negedge clk);
    check("reset clears game_over", game_over, 0);
    reset = 1'b0;

    // Simultaneous spawn and move: spawn wins, move not consumed.
    set_shape(0);
    issue(1'b1, 4'd3, OP_L, got, lat, acc, lk);
    check("pre-sim spawn accepted", acc, 1);
    @(negedge clk);
    @(negedge clk);
    spawn_valid = 1'b1;
    spawn_x     = 4'd6;
    move_valid  = 1'b1;
    move_op     = OP_R;
    #1;
    check("sim move_ready", move_ready, 0);
    @(negedge clk);
    spawn_valid = 1'b0;
    move_valid  = 1'b0;
    lat = 1;
    while (!done && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    check("sim latency", lat, 2);
    check("sim accepted", accepted, 1);
    @(negedge clk);
    check("sim piece_x", piece_x, 6);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("sim extra done", extra, 0);

    // Reset asserted while the request sits in SAMPLE.
    spawn_valid = 1'b1;
    spawn_x     = 4'd2;
    @(negedge clk);
    spawn_valid = 1'b0;
    check("sample piece_x", piece_x, 2);
    reset = 1'b1;
    @(negedge clk);
    check_zero("mid-reset");
    reset = 1'b0;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("mid-reset no done", extra, 0);
    check("mid-reset move_ready", move_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piece_move_validator.md
Name: piece_move_validator

Overview:
- Owns the active piece's position and rotation registers.
- Drives `piece_x`/`piece_y` into the piece_mask_generator and consumes the 6x6 window it returns.
- Checks each requested move (left, right, down, rotate) or spawn against the board, then commits or rejects it.
- Flags piece lock on a blocked DOWN and game-over on a blocked spawn; sits between the input/gravity controller and board-merge logic.

Parameters:
- BOARD_WIDTH, 10, board columns
- BOARD_HEIGHT, 20, board rows

Ports:
- clk  in  1  game clock
- reset  in  1  synchronous, active-high reset
- spawn_valid  in  1  request new piece at (spawn_x, 0), rotation 0
- spawn_x  in  $clog2(BOARD_WIDTH)  spawn column of the mask origin
- move_valid  in  1  move request; accepted only when move_ready=1
- move_op  in  2  0=LEFT, 1=RIGHT, 2=DOWN, 3=ROT_CW
- move_ready  out  1  high in IDLE when spawn_valid=0 and game_over=0
- cur_mask  in  16  shape ROM output for piece_rot; bit 4*r+c = cell (col c, row r)
- next_mask  in  16  shape ROM output for (piece_rot+1) mod 4
- window  in  [5:0] x6  from piece_mask_generator; window[lx][ly] = cell (piece_x+lx-1, piece_y+ly-1); off-board = 1
- piece_x  out  $clog2(BOARD_WIDTH)  mask origin column
- piece_y  out  $clog2(BOARD_HEIGHT)  mask origin row
- piece_rot  out  2  rotation index
- piece_active  out  1  a piece is in play
- done  out  1  one-cycle pulse; request resolved
- accepted  out  1  valid with done; 1 = move/spawn committed
- locked  out  1  one-cycle pulse with done; DOWN was blocked
- game_over  out  1  sticky; spawn collided

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset mid-operation aborts the request; no done pulse is produced.
- States: IDLE, SAMPLE, EVAL.
- Cycle 0, IDLE:
  - spawn_valid=1 and game_over=0: latch kind=SPAWN; piece_x<=spawn_x, piece_y<=0, piece_rot<=0, piece_active<=1; go to SAMPLE.
  - Otherwise, move_valid=1, move_ready=1 and piece_active=1: latch kind=MOVE and op; go to SAMPLE.
  - move_valid while piece_active=0: ignored, no done.
- Simultaneous spawn_valid and move_valid: spawn wins; move_ready is 0 that cycle, so the move is not consumed.
- Cycle 1, SAMPLE: register window into window_q, cur_mask into cur_q, next_mask into next_q; go to EVAL.
- Cycle 2, EVAL: compute hit; assert done for exactly this cycle; return to IDLE. Total latency, request to done, is 2 cycles.
- Hit computation with offset (dx,dy): hit = OR over set bits (c,r) of the mask of window_q[c+1+dx][r+1+dy].
  - SPAWN: cur_q, (0,0).
  - LEFT: cur_q, (-1,0).
  - RIGHT: cur_q, (+1,0).
  - DOWN: cur_q, (0,+1).
  - ROT_CW: next_q, (0,0).
- Register-range guards force a blocked result regardless of window:
  - LEFT at piece_x=0.
  - RIGHT at piece_x=BOARD_WIDTH-1.
  - DOWN at piece_y=BOARD_HEIGHT-1.
- Committed MOVE (hit=0): accepted=1; apply x±1, y+1, or rot+1 (mod 4, wraps 3->0).
- Rejected MOVE: accepted=0; position unchanged.
- Rejected DOWN: additionally locked=1 and piece_active<=0.
- SPAWN with hit=0: accepted=1.
- SPAWN with hit=1: accepted=0, game_over<=1, piece_active<=0. game_over stays set until reset; spawns are ignored while it is set.
- Requests arriving in SAMPLE/EVAL are not accepted (move_ready=0).
- Outputs piece_x/y/rot are registered; the window changes the cycle after a commit, so the next evaluation uses the new position.

Test Plan:
- Reset, then empty board, spawn_valid with spawn_x=3 -> done at cycle 2, accepted=1, piece_x=3, piece_y=0, piece_active=1, game_over=0.
- Piece at x=0 with O-mask (0x0033), move_op=LEFT -> done, accepted=0, locked=0, piece_x stays 0; RIGHT at x=BOARD_WIDTH-1 -> rejected.
- O-piece with bottom cells on row 18, DOWN -> done, accepted=0, locked=1, piece_active=0; a following move_valid gets no done.
- I-piece (rot 0), board cell under rot-1 footprint set (window_q[2][3]=1), ROT_CW -> accepted=0, piece_rot unchanged; after clearing that cell -> accepted=1, piece_rot=1; four accepted rotations -> piece_rot returns to 0.
- Spawn where window[1][1]=1 under cur_mask bit 0 -> accepted=0, game_over=1 (sticky), move_ready=0; later spawn_valid ignored until reset.
- spawn_valid and move_valid in the same IDLE cycle -> spawn processed, move_ready=0 that cycle; reset asserted in SAMPLE -> no done, all outputs 0 next cycle.
